// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - in-order ALU instruction FIFO dispatching into two reservation-station slots
// Optional same-edge bypass of an empty FIFO: define ALU_DISPATCH_BYPASS_EN.
module alu_dispatch #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 32,
    parameter int              OP_W     = 6,
    parameter int              TAG_W    = 5,
    parameter int              WORD_W   = 32,
    parameter int              RA_W     = 5,
    parameter logic [TAG_W-1:0] UNLOCKED = '1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PC_W-1:0]             in_pc,
    input  logic [OP_W-1:0]             in_op,
    input  logic [TAG_W-1:0]            in_tagx,
    input  logic [TAG_W-1:0]            in_tagy,
    input  logic [TAG_W-1:0]            in_tagw,
    input  logic [WORD_W-1:0]           in_datax,
    input  logic [WORD_W-1:0]           in_datay,
    input  logic [RA_W-1:0]             in_addrw,
    input  logic                        busy_alu0,
    input  logic                        busy_alu1,
    output logic                        en0,
    output logic                        en1,
    output logic [PC_W-1:0]             out_pc,
    output logic [OP_W-1:0]             out_op,
    output logic [TAG_W-1:0]            out_tagx,
    output logic [TAG_W-1:0]            out_tagy,
    output logic [TAG_W-1:0]            out_tagw,
    output logic [WORD_W-1:0]           out_datax,
    output logic [WORD_W-1:0]           out_datay,
    output logic [RA_W-1:0]             out_addrw,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IW    = PC_W + OP_W + 3 * TAG_W + 2 * WORD_W + RA_W;

    logic [IW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_pend0;
    logic             r_pend1;
    logic             r_last_grant;
    logic             r_en0;
    logic             r_en1;
    logic [IW-1:0]    r_out;

    logic [IW-1:0]    w_in_word;
    logic [IW-1:0]    w_reset_word;
    logic [IW-1:0]    w_disp_word;
    logic             w_free0;
    logic             w_free1;
    logic             w_any_free;
    logic             w_fifo_pop;
    logic             w_accept;
    logic             w_bypass;
    logic             w_push;
    logic             w_dispatch;
    logic             w_sel;

    assign w_in_word    = {in_pc, in_op, in_tagx, in_tagy, in_tagw, in_datax, in_datay, in_addrw};
    assign w_reset_word = {{PC_W{1'b0}}, {OP_W{1'b0}}, UNLOCKED, UNLOCKED, UNLOCKED,
                           {WORD_W{1'b0}}, {WORD_W{1'b0}}, {RA_W{1'b0}}};

    // A slot stays unavailable for the cycle after its strobe, until its busy flag catches up.
    assign w_free0    = !busy_alu0 && !r_pend0;
    assign w_free1    = !busy_alu1 && !r_pend1;
    assign w_any_free = w_free0 || w_free1;

    assign w_fifo_pop = rst && rdy && !flush && (r_count != '0) && w_any_free;
    assign in_ready   = rst && rdy && !flush && ((r_count < CNT_W'(DEPTH)) || w_fifo_pop);
    assign w_accept   = in_valid && in_ready;

`ifdef ALU_DISPATCH_BYPASS_EN
    assign w_bypass    = w_accept && (r_count == '0) && w_any_free;
    assign w_disp_word = w_bypass ? w_in_word : r_mem[r_rd_ptr];
`else
    assign w_bypass    = 1'b0;
    assign w_disp_word = r_mem[r_rd_ptr];
`endif

    assign w_push     = w_accept && !w_bypass;
    assign w_dispatch = w_fifo_pop || w_bypass;
    // Both free: alternate away from the previous grant; otherwise take whichever is free.
    assign w_sel      = (w_free0 && w_free1) ? ~r_last_grant : !w_free0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_pend0      <= 1'b0;
            r_pend1      <= 1'b0;
            r_last_grant <= 1'b1;
            r_en0        <= 1'b0;
            r_en1        <= 1'b0;
            r_out        <= w_reset_word;
        end else begin
            r_en0 <= 1'b0;
            r_en1 <= 1'b0;
            if (rdy) begin
                if (flush) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                    r_pend0  <= 1'b0;
                    r_pend1  <= 1'b0;
                end else begin
                    r_pend0 <= w_dispatch && !w_sel;
                    r_pend1 <= w_dispatch && w_sel;
                    if (w_dispatch) begin
                        r_en0        <= !w_sel;
                        r_en1        <= w_sel;
                        r_last_grant <= w_sel;
                        r_out        <= w_disp_word;
                    end
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    end
                    if (w_fifo_pop) begin
                        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    end
                    r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_fifo_pop);
                end
            end
        end
    end

    assign en0   = r_en0;
    assign en1   = r_en1;
    assign count = r_count;
    assign {out_pc, out_op, out_tagx, out_tagy, out_tagw, out_datax, out_datay, out_addrw} = r_out;

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - directed and random checks of alu_dispatch against a queue-based reference
module tb_alu_dispatch;

    localparam int         DEPTH = 4;
    localparam logic [4:0] UNL   = 5'h1f;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_datax, in_datay;
    logic [5:0]  in_op;
    logic [4:0]  in_tagx, in_tagy, in_tagw, in_addrw;
    logic        busy_alu0, busy_alu1, en0, en1;
    logic [31:0] out_pc, out_datax, out_datay;
    logic [5:0]  out_op;
    logic [4:0]  out_tagx, out_tagy, out_tagw, out_addrw;
    logic [2:0]  count;

    always #5 clk = ~clk;

    alu_dispatch dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_op(in_op), .in_tagx(in_tagx), .in_tagy(in_tagy), .in_tagw(in_tagw),
        .in_datax(in_datax), .in_datay(in_datay), .in_addrw(in_addrw),
        .busy_alu0(busy_alu0), .busy_alu1(busy_alu1), .en0(en0), .en1(en1),
        .out_pc(out_pc), .out_op(out_op), .out_tagx(out_tagx), .out_tagy(out_tagy),
        .out_tagw(out_tagw), .out_datax(out_datax), .out_datay(out_datay),
        .out_addrw(out_addrw), .count(count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [31:0] dx;
    } ins_t;

    ins_t q[$];
    ins_t mout;
    bit   mp0, mp1, mlast, men0, men1;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_op    = 6'($urandom);
        in_tagx  = 5'($urandom);
        in_tagy  = 5'($urandom);
        in_tagw  = 5'($urandom);
        in_datax = $urandom;
        in_datay = $urandom;
        in_addrw = 5'($urandom);
    endtask

    // One clock: predict in_ready, advance the reference, then compare registered outputs.
    task automatic cycle();
        bit   f0, f1, dsp, byp, rd, sl;
        ins_t cur;
        #2;
        cur = {in_pc, in_op, in_datax};
        f0  = !busy_alu0 && !mp0;
        f1  = !busy_alu1 && !mp1;
        dsp = (q.size() != 0) && (f0 || f1);
        rd  = rst && rdy && !flush && ((q.size() < DEPTH) || dsp);
        byp = 1'b0;
`ifdef ALU_DISPATCH_BYPASS_EN
        byp = rd && in_valid && (q.size() == 0) && (f0 || f1);
`endif
        chk("in_ready", in_ready, rd);
        if (!rst) begin
            q.delete();
            mp0 = 0; mp1 = 0; mlast = 1; men0 = 0; men1 = 0; mout = '0;
        end else begin
            men0 = 0;
            men1 = 0;
            if (rdy) begin
                mp0 = 0;
                mp1 = 0;
                if (flush) begin
                    q.delete();
                end else begin
                    sl = (f0 && f1) ? !mlast : !f0;
                    if (dsp || byp) begin
                        mout = byp ? cur : q.pop_front();
                        if (sl) begin men1 = 1; mp1 = 1; end
                        else    begin men0 = 1; mp0 = 1; end
                        mlast = sl;
                    end
                    if (in_valid && rd && !byp) q.push_back(cur);
                end
            end
        end
        @(posedge clk);
        #1;
        chk("en0", en0, men0);
        chk("en1", en1, men1);
        chk("en_excl", en0 & en1, 1'b0);
        chk("count", count, 64'(q.size()));
        chk("out_pc", out_pc, mout.pc);
        chk("out_op", out_op, mout.op);
        chk("out_datax", out_datax, mout.dx);
    endtask

    task automatic step(input bit v, input logic [31:0] pc);
        drive(v, pc);
        cycle();
    endtask

    initial begin
        rst = 0; rdy = 1; flush = 0; busy_alu0 = 0; busy_alu1 = 0;
        drive(0, 0);
        mp0 = 0; mp1 = 0; mlast = 1; men0 = 0; men1 = 0; mout = '0;
        cycle();
        rdy = 0;
        cycle();
        chk("rst_tagx", out_tagx, UNL);
        chk("rst_tagy", out_tagy, UNL);
        chk("rst_tagw", out_tagw, UNL);
        chk("rst_addrw", out_addrw, 5'h0);
        rst = 1; rdy = 1;

        // single instruction, both slots free
        step(1, 32'h100);
`ifdef ALU_DISPATCH_BYPASS_EN
        chk("byp_en0", en0, 1'b1);
        chk("byp_count", count, 3'd0);
`else
        chk("lat_no_en", en0 | en1, 1'b0);
        step(0, 0);
        chk("first_en0", en0, 1'b1);
        chk("first_pc", out_pc, 32'h100);
`endif
        step(0, 0);
        chk("first_count", count, 3'd0);

        // back-to-back stream alternates slots
        for (int i = 0; i < 4; i++) step(1, 32'(i * 4));
        for (int i = 0; i < 4; i++) step(0, 0);

        // full FIFO, then release slot 1 with a simultaneous push
        busy_alu0 = 1; busy_alu1 = 1;
        for (int i = 0; i < 5; i++) step(1, 32'h200 + 32'(i * 4));
        chk("full_count", count, 3'd4);
        chk("full_ready", in_ready, 1'b0);
        busy_alu1 = 0;
        step(1, 32'h210);
        chk("rel_en1", en1, 1'b1);
        chk("rel_pc", out_pc, 32'h200);
        chk("rel_count", count, 3'd4);
        busy_alu0 = 0;
        for (int i = 0; i < 6; i++) step(0, 0);

        // flush with a concurrent push
        busy_alu0 = 1; busy_alu1 = 1;
        for (int i = 0; i < 3; i++) step(1, 32'h300 + 32'(i * 4));
        flush = 1;
        step(1, 32'h3f0);
        chk("flush_count", count, 3'd0);
        flush = 0; busy_alu0 = 0; busy_alu1 = 0;
        step(0, 0);
        step(0, 0);

        // stall with rdy low, then resume
        busy_alu0 = 1; busy_alu1 = 1;
        step(1, 32'h400);
        step(1, 32'h404);
        busy_alu0 = 0; busy_alu1 = 0; rdy = 0;
        for (int i = 0; i < 3; i++) step(1, 32'h4f0);
        chk("stall_count", count, 3'd2);
        rdy = 1;
        for (int i = 0; i < 3; i++) step(0, 0);

        // reset mid-operation
        step(1, 32'h500);
        step(1, 32'h504);
        rst = 0;
        step(1, 32'h508);
        rst = 1;
        step(0, 0);
        chk("rst_mid_en", en0 | en1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 63) != 0);
            rdy       = ($urandom_range(0, 99) < 85);
            flush     = ($urandom_range(0, 99) < 5);
            busy_alu0 = ($urandom_range(0, 99) < 30);
            busy_alu1 = ($urandom_range(0, 99) < 30);
            step($urandom_range(0, 99) < 60, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
